ifm_pingpong_buffer: RTL and testbench

IFM_PINGPONG_BUFFER -- requirements
Module: ifm_pingpong_buffer

---
 rtl/ifm_buf_pkg.sv | 24 ++
 rtl/ifm_bank_ram.sv | 35 +++
 rtl/ifm_pingpong_buffer.sv | 182 ++++++++++++++++++
 tb/tb_ifm_pingpong_buffer.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/ifm_buf_pkg.sv
// rtl/ifm_buf_pkg.sv - shared types and constants for the IFM ping-pong buffer
// Purpose: bank-state encoding, read-latency constants and the round-robin
//          pointer helper used by ifm_pingpong_buffer.
// Ports:   none (package).
package ifm_buf_pkg;

    typedef enum logic [1:0] {
        BANK_EMPTY   = 2'd0,
        BANK_FILLING = 2'd1,
        BANK_FULL    = 2'd2
    } bank_state_t;

    localparam int RD_LAT_BASE   = 1;
    localparam int RD_LAT_OUTREG = 2;

    // Storage arrays are sized for the largest supported bank count so a
    // 2-bit pointer always indexes them in range.
    localparam int MAX_BANKS = 4;

    function automatic logic [1:0] next_ptr(input logic [1:0] ptr, input logic [2:0] num_banks);
        return ({1'b0, ptr} == num_banks - 3'd1) ? 2'd0 : ptr + 2'd1;
    endfunction

endpackage

// File: rtl/ifm_bank_ram.sv
// rtl/ifm_bank_ram.sv - one bank of simple dual-port RAM with synchronous read
// Purpose: DEPTH x DATA_W storage, one write port and one registered read port.
//          Contents are never reset so the array maps onto block RAM.
// Ports:   clk; we/waddr/wdata write port; re/raddr read request; q read data
//          (valid the cycle after re).
module ifm_bank_ram #(
    parameter int DATA_W = 128,
    parameter int ADDR_W = 10,
    parameter int DEPTH  = 1024
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] q
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DATA_W-1:0] mem [DEPTH];

    // Writes are only issued for addresses below DEPTH, so dropping the
    // upper address bits is safe; reads past DEPTH return undefined data.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr[IDX_W-1:0]] <= wdata;
        end
        if (re) begin
            q <= mem[raddr[IDX_W-1:0]];
        end
    end

endmodule

// File: rtl/ifm_pingpong_buffer.sv
// rtl/ifm_pingpong_buffer.sv - multi-bank ping-pong buffer for input feature maps
// Purpose: NUM_BANKS banks filled and drained round-robin. A writer fills the
//          current fill bank and closes it with wr_done; a reader reads the
//          oldest full bank and releases it with rd_done.
// Ports:   clk, rst (async, active high)
//          wr_en/wr_addr/wr_data, wr_done, wr_ready  - fill side
//          rd_en/rd_addr, rd_data/rd_valid, rd_done, rd_ready, rd_len - drain side
//          full_cnt - number of full banks
// Macro:   IFM_BUF_OUTREG_EN adds an output register (read latency 2 instead of 1).
module ifm_pingpong_buffer
    import ifm_buf_pkg::*;
#(
    parameter int DATA_W    = 128,
    parameter int ADDR_W    = 10,
    parameter int DEPTH     = 1024,
    parameter int NUM_BANKS = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              wr_done,
    output logic              wr_ready,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    input  logic              rd_done,
    output logic              rd_ready,
    output logic [ADDR_W:0]   rd_len,
    output logic [2:0]        full_cnt
);

`ifdef IFM_BUF_OUTREG_EN
    localparam int RD_LATENCY = RD_LAT_OUTREG;
`else
    localparam int RD_LATENCY = RD_LAT_BASE;
`endif

    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0] LEN_ONE = (ADDR_W+1)'(1);
    localparam logic [2:0]      NB      = 3'(NUM_BANKS);

    bank_state_t       bank_state     [MAX_BANKS];
    bank_state_t       bank_state_nxt [MAX_BANKS];
    logic [ADDR_W:0]   bank_len       [MAX_BANKS];
    logic [1:0]        fill_ptr, fill_ptr_nxt;
    logic [1:0]        drain_ptr, drain_ptr_nxt;
    logic [2:0]        full_cnt_nxt;
    logic [ADDR_W:0]   fill_len, fill_len_nxt;
    logic [ADDR_W:0]   wr_len_cand, len_upd;
    logic              wr_accept, wr_close, rd_fire, rd_close;

    logic [DATA_W-1:0] ram_q [MAX_BANKS];
    logic [DATA_W-1:0] ram_data;
    logic [1:0]        rd_bank_q;
    logic              rd_valid_q;

    assign wr_accept   = wr_en & wr_ready & ({1'b0, wr_addr} < DEPTH_L);
    assign wr_close    = wr_done & wr_ready;
    assign rd_fire     = rd_en & rd_ready;
    assign rd_close    = rd_done & rd_ready;

    // Running length of the open bank, including a write in the closing cycle.
    assign wr_len_cand = {1'b0, wr_addr} + LEN_ONE;
    assign len_upd     = (wr_accept && (wr_len_cand > fill_len)) ? wr_len_cand : fill_len;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < MAX_BANKS; i++) begin
                bank_state[i] <= BANK_EMPTY;
                bank_len[i]   <= '0;
            end
            fill_ptr  <= 2'd0;
            drain_ptr <= 2'd0;
            full_cnt  <= 3'd0;
            fill_len  <= '0;
        end else begin
            bank_state <= bank_state_nxt;
            fill_ptr   <= fill_ptr_nxt;
            drain_ptr  <= drain_ptr_nxt;
            full_cnt   <= full_cnt_nxt;
            fill_len   <= fill_len_nxt;
            if (wr_close) begin
                bank_len[fill_ptr] <= len_upd;
            end
        end
    end

    // Next-state logic. An accepted wr_done always targets a non-full bank and
    // an accepted rd_done a full one, so the two never hit the same bank.
    always_comb begin
        bank_state_nxt = bank_state;
        fill_ptr_nxt   = fill_ptr;
        drain_ptr_nxt  = drain_ptr;
        full_cnt_nxt   = full_cnt;
        fill_len_nxt   = len_upd;
        if (wr_accept && (bank_state[fill_ptr] == BANK_EMPTY)) begin
            bank_state_nxt[fill_ptr] = BANK_FILLING;
        end
        if (wr_close) begin
            bank_state_nxt[fill_ptr] = BANK_FULL;
            fill_ptr_nxt             = next_ptr(fill_ptr, NB);
            fill_len_nxt             = '0;
        end
        if (rd_close) begin
            bank_state_nxt[drain_ptr] = BANK_EMPTY;
            drain_ptr_nxt             = next_ptr(drain_ptr, NB);
        end
        case ({wr_close, rd_close})
            2'b10:   full_cnt_nxt = full_cnt + 3'd1;
            2'b01:   full_cnt_nxt = full_cnt - 3'd1;
            default: full_cnt_nxt = full_cnt;
        endcase
    end

    // Outputs
    always_comb begin
        wr_ready = (full_cnt < NB);
        rd_ready = (full_cnt != 3'd0);
        rd_len   = rd_ready ? bank_len[drain_ptr] : '0;
    end

    for (genvar i = 0; i < MAX_BANKS; i++) begin : g_bank
        if (i < NUM_BANKS) begin : g_ram
            ifm_bank_ram #(
                .DATA_W(DATA_W),
                .ADDR_W(ADDR_W),
                .DEPTH (DEPTH)
            ) u_ram (
                .clk  (clk),
                .we   (wr_accept && (fill_ptr == 2'(i))),
                .waddr(wr_addr),
                .wdata(wr_data),
                .re   (rd_fire && (drain_ptr == 2'(i))),
                .raddr(rd_addr),
                .q    (ram_q[i])
            );
        end else begin : g_none
            assign ram_q[i] = '0;
        end
    end

    // The bank index travels with the request so a response in flight across
    // an rd_done still selects the bank it was issued to.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_valid_q <= 1'b0;
            rd_bank_q  <= 2'd0;
        end else begin
            rd_valid_q <= rd_fire;
            if (rd_fire) begin
                rd_bank_q <= drain_ptr;
            end
        end
    end

    // RAM output is not reset; gating keeps rd_data at zero when idle.
    assign ram_data = rd_valid_q ? ram_q[rd_bank_q] : '0;

    if (RD_LATENCY > RD_LAT_BASE) begin : g_outreg
        logic [DATA_W-1:0] data_q;
        logic              valid_q;
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                data_q  <= '0;
                valid_q <= 1'b0;
            end else begin
                data_q  <= ram_data;
                valid_q <= rd_valid_q;
            end
        end
        assign rd_data  = data_q;
        assign rd_valid = valid_q;
    end else begin : g_direct
        assign rd_data  = ram_data;
        assign rd_valid = rd_valid_q;
    end

endmodule

// File: tb/tb_ifm_pingpong_buffer.sv
// tb/tb_ifm_pingpong_buffer.sv - directed self-checking bench for ifm_pingpong_buffer
module tb_ifm_pingpong_buffer;

`ifdef IFM_BUF_OUTREG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    localparam int DATA_W    = 128;
    localparam int ADDR_W    = 11;
    localparam int DEPTH     = 1024;
    localparam int NUM_BANKS = 2;

    logic              clk = 1'b0;
    logic              rst;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              wr_done;
    logic              wr_ready;
    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] rd_data;
    logic              rd_valid;
    logic              rd_done;
    logic              rd_ready;
    logic [ADDR_W:0]   rd_len;
    logic [2:0]        full_cnt;

    int n_checks = 0;
    int n_errors = 0;

    ifm_pingpong_buffer #(
        .DATA_W   (DATA_W),
        .ADDR_W   (ADDR_W),
        .DEPTH    (DEPTH),
        .NUM_BANKS(NUM_BANKS)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .wr_done (wr_done),
        .wr_ready(wr_ready),
        .rd_en   (rd_en),
        .rd_addr (rd_addr),
        .rd_data (rd_data),
        .rd_valid(rd_valid),
        .rd_done (rd_done),
        .rd_ready(rd_ready),
        .rd_len  (rd_len),
        .full_cnt(full_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_write(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        wr_en   = 1'b1;
        wr_addr = a;
        wr_data = d;
        step();
        wr_en   = 1'b0;
    endtask

    task automatic do_close();
        wr_done = 1'b1;
        step();
        wr_done = 1'b0;
    endtask

    task automatic do_release();
        rd_done = 1'b1;
        step();
        rd_done = 1'b0;
    endtask

    task automatic read_check(input string tag, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] exp);
        rd_en   = 1'b1;
        rd_addr = a;
        step();
        rd_en   = 1'b0;
        repeat (LAT - 1) step();
        chk({tag, "_valid"}, rd_valid, 1'b1);
        chk({tag, "_data"}, rd_data, exp);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0; wr_done = 1'b0;
        rd_en = 1'b0; rd_addr = '0; rd_done = 1'b0;
        step();
        step();
        chk("rst_wr_ready", wr_ready, 1'b1);
        chk("rst_rd_ready", rd_ready, 1'b0);
        chk("rst_full_cnt", full_cnt, 3'd0);
        chk("rst_rd_len", rd_len, '0);
        chk("rst_rd_valid", rd_valid, 1'b0);
        chk("rst_rd_data", rd_data, '0);
        rst = 1'b0;
        step();

        // Bank 0: addresses 0..9, plus an out-of-range write that must be dropped.
        for (int a = 0; a < 10; a++) do_write(ADDR_W'(a), 128'h1000 + 128'(a));
        do_write(11'd1030, 128'hBAD);
        do_close();
        chk("b0_full_cnt", full_cnt, 3'd1);
        chk("b0_rd_ready", rd_ready, 1'b1);
        chk("b0_rd_len", rd_len, 12'd10);
        chk("b0_wr_ready", wr_ready, 1'b1);
        read_check("b0_rd5", 11'd5, 128'h1005);
        read_check("b0_rd0", 11'd0, 128'h1000);
        read_check("b0_rd9", 11'd9, 128'h1009);

        // Bank 1: last write coincides with wr_done and must be counted.
        for (int a = 0; a < 3; a++) do_write(ADDR_W'(a), 128'h2000 + 128'(a));
        wr_en = 1'b1; wr_addr = 11'd3; wr_data = 128'h2003; wr_done = 1'b1;
        step();
        wr_en = 1'b0; wr_done = 1'b0;
        chk("both_full_cnt", full_cnt, 3'd2);
        chk("both_wr_ready", wr_ready, 1'b0);
        chk("both_rd_len", rd_len, 12'd10);

        // No free bank: write and wr_done are both ignored.
        wr_en = 1'b1; wr_addr = 11'd0; wr_data = 128'hDEAD; wr_done = 1'b1;
        step();
        wr_en = 1'b0; wr_done = 1'b0;
        chk("drop_full_cnt", full_cnt, 3'd2);
        read_check("drop_rd0", 11'd0, 128'h1000);

        do_release();
        chk("rel0_full_cnt", full_cnt, 3'd1);
        chk("rel0_rd_len", rd_len, 12'd4);
        chk("rel0_wr_ready", wr_ready, 1'b1);
        read_check("b1_rd3", 11'd3, 128'h2003);

        // Bank 0 reopened with 7 words, then close + release + read together.
        for (int a = 0; a < 7; a++) do_write(ADDR_W'(a), 128'h3000 + 128'(a));
        wr_done = 1'b1; rd_done = 1'b1; rd_en = 1'b1; rd_addr = 11'd2;
        step();
        wr_done = 1'b0; rd_done = 1'b0; rd_en = 1'b0;
        chk("swap_full_cnt", full_cnt, 3'd1);
        chk("swap_rd_len", rd_len, 12'd7);
        chk("swap_wr_ready", wr_ready, 1'b1);
        repeat (LAT - 1) step();
        chk("inflight_valid", rd_valid, 1'b1);
        chk("inflight_data", rd_data, 128'h2002);
        read_check("b0b_rd6", 11'd6, 128'h3006);
        rd_en = 1'b1; rd_addr = 11'd8;
        step();
        rd_en = 1'b0;
        repeat (LAT - 1) step();
        chk("past_len_valid", rd_valid, 1'b1);

        do_release();
        chk("empty_full_cnt", full_cnt, 3'd0);
        chk("empty_rd_ready", rd_ready, 1'b0);
        chk("empty_rd_len", rd_len, '0);
        rd_en = 1'b1; rd_addr = 11'd0;
        step();
        rd_en = 1'b0;
        repeat (LAT - 1) step();
        chk("norready_valid", rd_valid, 1'b0);
        chk("norready_data", rd_data, '0);

        // Bank 1 full with 5 words, bank 0 mid-fill, then reset with a read in flight.
        for (int a = 0; a < 5; a++) do_write(ADDR_W'(a), 128'h4000 + 128'(a));
        do_close();
        chk("pre_rst_rd_len", rd_len, 12'd5);
        for (int a = 0; a < 3; a++) do_write(ADDR_W'(a), 128'h4100 + 128'(a));
        rst = 1'b1; rd_en = 1'b1; rd_addr = 11'd0;
        step();
        rd_en = 1'b0; rst = 1'b0;
        chk("mid_rst_wr_ready", wr_ready, 1'b1);
        chk("mid_rst_rd_ready", rd_ready, 1'b0);
        chk("mid_rst_rd_len", rd_len, '0);
        chk("mid_rst_full_cnt", full_cnt, 3'd0);
        chk("mid_rst_rd_valid", rd_valid, 1'b0);
        step();

        // Fresh bank after reset, then a back-to-back read stream.
        for (int a = 0; a < 3; a++) do_write(ADDR_W'(a), 128'h5000 + 128'(a));
        do_close();
        chk("post_rst_rd_len", rd_len, 12'd3);
        for (int c = 0; c < 3 + LAT; c++) begin
            int idx;
            rd_en   = (c < 3);
            rd_addr = ADDR_W'(c);
            step();
            idx = c - (LAT - 1);
            if (idx >= 0 && idx < 3) begin
                chk($sformatf("stream%0d_valid", idx), rd_valid, 1'b1);
                chk($sformatf("stream%0d_data", idx), rd_data, 128'h5000 + 128'(idx));
            end else if (idx >= 3) begin
                chk("stream_end_valid", rd_valid, 1'b0);
            end
        end
        rd_en = 1'b0;

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
